// File: rtl/alarm_match_ctrl_pkg.sv
// Shared definitions for the alarm sequencer: widths, state encoding, time limits.
package alarm_match_ctrl_pkg;

    localparam int unsigned TIME_W  = 6;
    localparam int unsigned TIMER_W = 9;
    localparam int unsigned SNZ_W   = 3;
    localparam int unsigned STATE_W = 2;

    localparam logic [TIME_W-1:0] MAX_SEC = TIME_W'(59);

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } alarm_state_e;

    // True when both fields are legal mm:ss values
    function automatic logic time_valid(input logic [TIME_W-1:0] mins,
                                        input logic [TIME_W-1:0] secs);
        return (mins <= MAX_SEC) && (secs <= MAX_SEC);
    endfunction

endpackage

// File: rtl/alarm_match_ctrl_sec_timer.sv
// Seconds counter for the ring/snooze phases; flags the tick that reaches the limit.
module alarm_match_ctrl_sec_timer
    import alarm_match_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               tick_i,
    input  logic [TIMER_W-1:0] limit_i,
    output logic               done_c
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W:0]   count_inc_c;

    // Extra bit keeps the compare exact even with the counter pinned at all-ones
    assign count_inc_c = {1'b0, count_q} + (TIMER_W+1)'(1);
    assign done_c      = tick_i && (count_inc_c == {1'b0, limit_i});

    // Saturating tick counter with synchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (tick_i && (count_q != '1)) begin
            count_q <= count_inc_c[TIMER_W-1:0];
        end
    end

endmodule

// File: rtl/alarm_match_ctrl.sv
// Alarm sequencer: compares mm:ss with the stored alarm, drives ring/flash, handles snooze/dismiss.
module alarm_match_ctrl
    import alarm_match_ctrl_pkg::*;
#(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_1hz,
    input  logic [TIME_W-1:0]  cur_min,
    input  logic [TIME_W-1:0]  cur_sec,
    input  logic               arm,
    input  logic               set_en,
    input  logic [TIME_W-1:0]  set_min,
    input  logic [TIME_W-1:0]  set_sec,
    input  logic               snooze_btn,
    input  logic               dismiss_btn,
    output logic               ring,
    output logic               flash,
    output logic               set_err,
    output logic [STATE_W-1:0] state
);

    localparam logic [TIMER_W-1:0] RING_LIM   = TIMER_W'(RING_SECS);
    localparam logic [TIMER_W-1:0] SNOOZE_LIM = TIMER_W'(SNOOZE_SECS);
    localparam logic [SNZ_W-1:0]   SNZ_LIM    = SNZ_W'(MAX_SNOOZE);

    alarm_state_e        state_q;
    logic [TIME_W-1:0]   alm_min_q;
    logic [TIME_W-1:0]   alm_sec_q;
    logic [SNZ_W-1:0]    snz_cnt_q;

    logic                set_ok_c;
    logic                match_c;
    logic                in_ring_c;
    logic                in_snz_c;
    logic                snz_exhausted_c;
    logic                timer_en_c;
    logic                timer_clr_c;
    logic [TIMER_W-1:0]  timer_lim_c;
    logic                timer_done_c;

    // Decode of this cycle's requests and phase-timer control
    assign set_ok_c        = set_en && time_valid(set_min, set_sec);
    assign match_c         = tick_1hz && (cur_min == alm_min_q) && (cur_sec == alm_sec_q);
    assign in_ring_c       = (state_q == ST_RINGING);
    assign in_snz_c        = (state_q == ST_SNOOZE);
    assign snz_exhausted_c = (snz_cnt_q >= SNZ_LIM);
    assign timer_en_c      = tick_1hz && (in_ring_c || in_snz_c);
    assign timer_lim_c     = in_ring_c ? RING_LIM : SNOOZE_LIM;
    // Timer restarts on every exit from ringing/snoozing and stays clear elsewhere
    assign timer_clr_c     = !arm || !(in_ring_c || in_snz_c) || set_ok_c || dismiss_btn
                           || (in_ring_c && snooze_btn) || timer_done_c;

    alarm_match_ctrl_sec_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (timer_clr_c),
        .tick_i  (timer_en_c),
        .limit_i (timer_lim_c),
        .done_c  (timer_done_c)
    );

    assign state = state_q;

    // Alarm registers, set_err pulse and the sequencing FSM with its registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            alm_min_q <= '0;
            alm_sec_q <= '0;
            snz_cnt_q <= '0;
            ring      <= 1'b0;
            flash     <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            set_err <= set_en && !set_ok_c;
            if (set_ok_c) begin
                alm_min_q <= set_min;
                alm_sec_q <= set_sec;
            end

            if (!arm) begin
                state_q   <= ST_IDLE;
                snz_cnt_q <= '0;
                ring      <= 1'b0;
                flash     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ARMED;
                        ring    <= 1'b0;
                        flash   <= 1'b0;
                    end
                    ST_ARMED: begin
                        if (!set_ok_c && match_c) begin
                            state_q <= ST_RINGING;
                            ring    <= 1'b1;
                            flash   <= 1'b1;
                        end
                    end
                    ST_RINGING: begin
                        if (set_ok_c || dismiss_btn || (snooze_btn && snz_exhausted_c)) begin
                            state_q   <= ST_ARMED;
                            snz_cnt_q <= '0;
                            ring      <= 1'b0;
                            flash     <= 1'b0;
                        end else if (snooze_btn) begin
                            state_q   <= ST_SNOOZE;
                            snz_cnt_q <= snz_cnt_q + SNZ_W'(1);
                            ring      <= 1'b0;
                            flash     <= 1'b0;
                        end else if (timer_done_c) begin
                            state_q   <= ST_ARMED;
                            snz_cnt_q <= '0;
                            ring      <= 1'b0;
                            flash     <= 1'b0;
                        end else if (tick_1hz) begin
                            flash <= !flash;
                        end
                    end
                    ST_SNOOZE: begin
                        if (set_ok_c || dismiss_btn) begin
                            state_q   <= ST_ARMED;
                            snz_cnt_q <= '0;
                        end else if (timer_done_c) begin
                            state_q <= ST_RINGING;
                            ring    <= 1'b1;
                            flash   <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        ring    <= 1'b0;
                        flash   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_match_ctrl.sv
// Bench for alarm_match_ctrl: directed scenarios then random buttons/sets against a reference model.
module tb_alarm_match_ctrl;

    localparam int RING  = 4;
    localparam int SNZ   = 3;
    localparam int MAXS  = 2;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNOOZE = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic [5:0] cur_min, cur_sec;
    logic       arm, set_en;
    logic [5:0] set_min, set_sec;
    logic       snooze_btn, dismiss_btn;
    logic       ring, flash, set_err;
    logic [1:0] state;

    always #5 clk = ~clk;

    alarm_match_ctrl #(
        .RING_SECS   (RING),
        .SNOOZE_SECS (SNZ),
        .MAX_SNOOZE  (MAXS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .cur_min     (cur_min),
        .cur_sec     (cur_sec),
        .arm         (arm),
        .set_en      (set_en),
        .set_min     (set_min),
        .set_sec     (set_sec),
        .snooze_btn  (snooze_btn),
        .dismiss_btn (dismiss_btn),
        .ring        (ring),
        .flash       (flash),
        .set_err     (set_err),
        .state       (state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase, seconds spent in phase, snoozes used, stored alarm
    int m_state, m_secs, m_snz, m_amin, m_asec;
    bit m_err;
    int cmin, csec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_secs = 0; m_snz = 0; m_amin = 0; m_asec = 0; m_err = 0;
    endtask

    task automatic go_armed();
        m_state = M_ARMED; m_secs = 0; m_snz = 0;
    endtask

    // One clock of the model, priorities taken in the order the rules rank them
    task automatic model_step();
        bit bad, ok, hit;
        bad = set_en && (int'(set_min) > 59 || int'(set_sec) > 59);
        ok  = set_en && !bad;
        hit = tick_1hz && int'(cur_min) == m_amin && int'(cur_sec) == m_asec;
        m_err = bad;
        if (ok) begin m_amin = int'(set_min); m_asec = int'(set_sec); end
        if (!arm) begin
            m_state = M_IDLE; m_secs = 0; m_snz = 0;
        end else if (m_state == M_IDLE) begin
            m_state = M_ARMED;
        end else if (m_state == M_ARMED) begin
            if (!ok && hit) begin m_state = M_RING; m_secs = 0; end
        end else if (ok || dismiss_btn) begin
            go_armed();
        end else if (m_state == M_RING && snooze_btn) begin
            if (m_snz >= MAXS) go_armed();
            else begin m_state = M_SNOOZE; m_snz++; m_secs = 0; end
        end else if (tick_1hz) begin
            m_secs++;
            if (m_state == M_RING && m_secs == RING) go_armed();
            else if (m_state == M_SNOOZE && m_secs == SNZ) begin m_state = M_RING; m_secs = 0; end
        end
    endtask

    task automatic check_model();
        chk("model_state", 32'(state), 32'(m_state));
        chk("model_ring", 32'(ring), 32'(m_state == M_RING));
        chk("model_flash", 32'(flash), 32'(m_state == M_RING && (m_secs % 2) == 0));
        chk("model_set_err", 32'(set_err), 32'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_model();
        tick_1hz = 1'b0; set_en = 1'b0; snooze_btn = 1'b0; dismiss_btn = 1'b0;
    endtask

    task automatic drive_time();
        cur_min = 6'(cmin); cur_sec = 6'(csec);
    endtask

    task automatic jump(input int mm, input int ss);
        cmin = mm; csec = ss; drive_time();
    endtask

    // Nine quiet clocks, then the tick cycle carrying the next mm:ss
    task automatic second();
        repeat (9) step();
        csec++;
        if (csec == 60) begin csec = 0; cmin = (cmin + 1) % 60; end
        drive_time();
        tick_1hz = 1'b1;
        step();
    endtask

    task automatic press(input bit snz, input bit dis);
        snooze_btn = snz; dismiss_btn = dis; step();
    endtask

    task automatic do_set(input int mm, input int ss);
        set_min = 6'(mm); set_sec = 6'(ss); set_en = 1'b1; step();
    endtask

    initial begin
        reset = 1'b0; tick_1hz = 1'b0; arm = 1'b0; set_en = 1'b0;
        set_min = '0; set_sec = '0; snooze_btn = 1'b0; dismiss_btn = 1'b0;
        jump(0, 0);
        model_reset();
        #1 reset = 1'b1;
        #3;
        chk("rst_state", 32'(state), 0);
        chk("rst_ring", 32'(ring), 0);
        chk("rst_flash", 32'(flash), 0);
        chk("rst_set_err", 32'(set_err), 0);
        @(posedge clk); #1 reset = 1'b0;

        // 1: basic ring at 00:05, flash pattern, auto-stop after RING ticks
        do_set(0, 5);
        chk("t1_set_no_err", 32'(set_err), 0);
        arm = 1'b1;
        step();
        chk("t1_armed", 32'(state), 1);
        repeat (4) second();
        chk("t1_no_ring_early", 32'(ring), 0);
        second();
        chk("t1_ring_rise", 32'(ring), 1);
        chk("t1_flash0", 32'(flash), 1);
        second(); chk("t1_flash1", 32'(flash), 0);
        second(); chk("t1_flash2", 32'(flash), 1);
        second(); chk("t1_flash3", 32'(flash), 0);
        chk("t1_still_ring", 32'(ring), 1);
        second();
        chk("t1_autostop_ring", 32'(ring), 0);
        chk("t1_autostop_state", 32'(state), 1);

        // 2: snooze twice, third snooze dismisses
        jump(0, 4); second();
        chk("t2_ring", 32'(ring), 1);
        press(1, 0);
        chk("t2_snz1_state", 32'(state), 3);
        chk("t2_snz1_ring", 32'(ring), 0);
        second(); second();
        chk("t2_snz_wait", 32'(ring), 0);
        second();
        chk("t2_rering", 32'(ring), 1);
        chk("t2_rering_flash", 32'(flash), 1);
        press(1, 0);
        chk("t2_snz2_state", 32'(state), 3);
        repeat (3) second();
        chk("t2_rering2", 32'(ring), 1);
        press(1, 0);
        chk("t2_limit_state", 32'(state), 1);
        chk("t2_limit_ring", 32'(ring), 0);

        // 3: snooze+dismiss together dismisses and clears the snooze count
        jump(0, 4); second();
        press(1, 0);
        repeat (3) second();
        press(1, 1);
        chk("t3_both_state", 32'(state), 1);
        chk("t3_both_ring", 32'(ring), 0);
        jump(0, 4); second();
        press(1, 0);
        repeat (3) second();
        press(1, 0);
        chk("t3_cnt_cleared", 32'(state), 3);
        press(0, 1);
        chk("t3_dismiss_snz", 32'(state), 1);

        // 4: rejected and accepted sets
        do_set(60, 0);
        chk("t4_err_pulse", 32'(set_err), 1);
        step();
        chk("t4_err_once", 32'(set_err), 0);
        jump(0, 4); second();
        chk("t4_old_alarm", 32'(ring), 1);
        press(0, 1);
        do_set(0, 7);
        chk("t4_ok_no_err", 32'(set_err), 0);
        jump(0, 4); second();
        chk("t4_no_ring_05", 32'(ring), 0);
        second();
        chk("t4_no_ring_06", 32'(ring), 0);
        second();
        chk("t4_ring_07", 32'(ring), 1);

        // 5: disarm during snooze, then no ring while disarmed
        press(1, 0);
        chk("t5_snooze", 32'(state), 3);
        arm = 1'b0;
        step();
        chk("t5_idle", 32'(state), 0);
        jump(0, 6); second(); second();
        chk("t5_disarmed_ring", 32'(ring), 0);
        arm = 1'b1;
        step();
        chk("t5_rearmed", 32'(state), 1);

        // 6: async reset mid-ring, alarm returns to 00:00
        jump(0, 6); second();
        chk("t6_ring", 32'(ring), 1);
        step(); step();
        reset = 1'b1;
        #1;
        chk("t6_rst_ring", 32'(ring), 0);
        chk("t6_rst_flash", 32'(flash), 0);
        chk("t6_rst_state", 32'(state), 0);
        model_reset();
        @(posedge clk); #1 reset = 1'b0;
        jump(59, 59); second();
        chk("t6_alarm_zero", 32'(ring), 1);
        press(0, 1);

        // Random buttons, sets and arm drops with time running
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) snooze_btn = 1'b1;
            if (r == 3 || r == 4) dismiss_btn = 1'b1;
            if (r == 5) begin
                set_en = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    set_min = 6'(cmin);
                    set_sec = 6'((csec + int'($urandom_range(1, 3))) > 59 ? 59 : csec + int'($urandom_range(1, 3)));
                end else begin
                    set_min = 6'($urandom_range(0, 63));
                    set_sec = 6'($urandom_range(0, 63));
                end
            end
            if (r == 6) arm = 1'b0;
            else if (!arm && r < 30) arm = 1'b1;
            if (i % 10 == 9) begin
                csec++;
                if (csec == 60) begin csec = 0; cmin = (cmin + 1) % 60; end
                drive_time();
                tick_1hz = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
